// File: rtl/afft8_seq.sv
// Frame sequencer and sample-RAM arbiter for the afft8 engine; host owns RAM in IDLE, engine in RUN.
// Arbitration is combinational; fft_start/busy/irq decode the state register; host stalls (h_gnt=0) while busy.
module afft8_seq #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          clr,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic [DW-1:0] h_rdata,
  output logic          h_rvalid,
  input  logic          e_req,
  input  logic          e_we,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_wdata,
  output logic [DW-1:0] e_rdata,
  output logic          fft_start,
  input  logic          fft_done,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          irq,
  output logic          err_tmo,
  output logic          err_ovr,
  output logic [15:0]   run_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        done_hit;
  logic        tmo_hit;
  logic        ovr_hit;

  // done takes priority over a timeout landing in the same cycle
  assign done_hit = (state == RUN) && fft_done;
  assign tmo_hit  = (state == RUN) && !fft_done && (cnt == TMO_LAST);
  assign ovr_hit  = (state != IDLE) && go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (go) state_nxt = START;
      START: state_nxt = RUN;
      RUN:   if (done_hit || tmo_hit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fft_start = (state == START);
  assign busy      = (state != IDLE);
  assign irq       = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      run_cycles <= '0;
      err_tmo    <= 1'b0;
      err_ovr    <= 1'b0;
      h_rvalid   <= 1'b0;
    end else begin
      if (state == START)    cnt <= '0;
      else if (state == RUN) cnt <= cnt + 16'd1;
      // count includes the cycle that ends RUN
      if (done_hit || tmo_hit) run_cycles <= cnt + 16'd1;
      if (tmo_hit)  err_tmo <= 1'b1;
      else if (clr) err_tmo <= 1'b0;
      if (ovr_hit)  err_ovr <= 1'b1;
      else if (clr) err_ovr <= 1'b0;
      h_rvalid <= h_gnt & ~h_we;
    end
  end

  always_comb begin
    h_gnt   = 1'b0;
    m_addr  = '0;
    m_we    = 1'b0;
    m_wdata = '0;
    case (state)
      IDLE: begin
        h_gnt = h_req;
        if (h_req) begin
          m_addr  = h_addr;
          m_we    = h_we;
          m_wdata = h_wdata;
        end
      end
      RUN: begin
        if (e_req) begin
          m_addr  = e_addr;
          m_we    = e_we;
          m_wdata = e_wdata;
        end
      end
      default: ;
    endcase
  end

  assign h_rdata = m_rdata;
  assign e_rdata = m_rdata;

endmodule

// File: doc/afft8_seq.md
Name: afft8_seq

Overview:
Sequencer and bus arbiter for the 8-point FFT engine (afft8). It owns the single-port sample RAM shared between the host and the engine, and handles the frame lifecycle. The host loads samples, pulses go, the block issues a one-cycle start to the engine and hands it the RAM until the engine reports done. It then returns the RAM to the host and raises a completion pulse, with a timeout watchdog and sticky error flags.

Parameters:
AW, 16, RAM address width (matches engine addr)
DW, 32, RAM data width (matches engine data)
TIMEOUT, 1024, max cycles in RUN before abort; legal range 2..65535

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
go  in  1  host frame start request, single-cycle pulse
clr  in  1  clears sticky error flags
h_req  in  1  host RAM access request
h_we  in  1  host write enable (valid with h_req)
h_addr  in  AW  host RAM address
h_wdata  in  DW  host write data
h_gnt  out  1  host access accepted this cycle
h_rdata  out  DW  host read data
h_rvalid  out  1  h_rdata valid, one cycle after a granted read
e_req  in  1  engine RAM access request
e_we  in  1  engine write enable
e_addr  in  AW  engine RAM address
e_wdata  in  DW  engine write data
e_rdata  out  DW  engine read data (m_rdata passthrough)
fft_start  out  1  one-cycle start pulse to engine
fft_done  in  1  engine completion pulse
m_addr  out  AW  RAM address
m_we  out  1  RAM write strobe
m_wdata  out  DW  RAM write data
m_rdata  in  DW  RAM read data, synchronous read, 1-cycle latency
busy  out  1  frame in progress
irq  out  1  one-cycle frame-complete pulse (normal or timeout)
err_tmo  out  1  sticky: last frame timed out
err_ovr  out  1  sticky: go received while busy
run_cycles  out  16  cycles spent in RUN for last frame

Behaviour:
- Reset (async, rst_n=0) forces state IDLE.
  - All registered outputs go to 0: fft_start, irq, busy, h_rvalid, err_tmo, err_ovr, run_cycles, timeout counter.
- FSM states: IDLE, START, RUN, DONE.
  - IDLE: host owns the RAM. go=1 -> START.
  - START: fft_start=1 for exactly this cycle; busy=1; run counter cleared -> RUN.
  - RUN: engine owns the RAM; counter increments each cycle.
    - fft_done=1 -> DONE; run_cycles latches the count including the done cycle.
    - Counter reaches TIMEOUT-1 without done -> DONE with err_tmo set.
  - DONE: irq=1 for one cycle; busy drops to 0 on the next cycle -> IDLE.
- busy is 1 in START, RUN and DONE. fft_start is registered: it is high in the cycle after go was sampled.
- Arbitration (combinational mux):
  - IDLE: h_gnt = h_req. m_addr/m_we/m_wdata come from the host, with m_we = h_req & h_we.
  - START/RUN/DONE: h_gnt = 0 and host requests are stalled (the host holds h_req until granted). m_* come from the engine, with m_we = e_req & e_we.
  - e_req outside RUN is ignored: m_we=0 from the engine side.
  - Idle bus: m_we=0, m_addr=0.
- Read data:
  - h_rvalid is registered and equals (h_gnt & ~h_we) delayed one cycle.
  - h_rdata = m_rdata, valid only with h_rvalid.
  - e_rdata = m_rdata unconditionally.
- Simultaneous events:
  - go together with a host h_req in IDLE: the host access is granted this cycle and the state moves to START next cycle.
  - go in any non-IDLE state is ignored and sets err_ovr.
  - fft_done outside RUN is ignored.
  - fft_done in the same cycle the timeout would fire: done wins, err_tmo is not set.
- clr clears err_tmo/err_ovr. If a setting event occurs in the same cycle, set wins.
- Reset mid-frame returns to IDLE immediately. No irq is produced, and the engine must also be reset.

Test Plan:
- Host loads 8 words (addr 0..7, data 0x0001_0000..0x0008_0000), then reads addr 3 -> h_gnt high every cycle, h_rvalid one cycle later, h_rdata=0x0004_0000.
- go pulse at cycle N -> fft_start high only at N+1, busy high from N+1. Engine drives fft_done 40 cycles after start -> irq one cycle, run_cycles=40, busy low afterwards.
- h_req held during RUN -> h_gnt=0 and m_we follows e_req&e_we. Host is granted in the first IDLE cycle after DONE.
- No fft_done, TIMEOUT=16 -> DONE after 16 RUN cycles, err_tmo=1, irq pulses. clr pulse -> err_tmo=0.
- go during RUN -> err_ovr=1, frame continues normally, no second fft_start.
- rst_n low mid-RUN -> busy=0, h_gnt follows h_req immediately after release, no irq.
